// File: rtl/m_ifetch_queue.sv
// m_ifetch_queue: instruction fetch front end with a prefetch FIFO.
// Issues word-aligned fetches to a synchronous instruction memory with one
// cycle of latency. It buffers the returned (pc, ir) pairs and presents the
// oldest pair to decode first-word-fall-through over a valid/ready handshake.
// A redirect from EX flushes the buffer, drops any fetch still in flight and
// restarts fetching at the branch target.
//
// Ports:
//   w_clock      in   clock; all state updates on posedge
//   w_reset      in   synchronous active-high reset
//   w_imem_req   out  fetch request this cycle
//   w_imem_addr  out  fetch address (always the next fetch pc)
//   w_imem_data  in   instruction for the request issued in the previous cycle
//   w_redirect   in   taken branch from EX; flush and restart
//   w_tpc        in   redirect target; bits [1:0] are ignored
//   w_ready      in   decode accepts the head entry
//   w_valid      out  head entry available
//   w_ir         out  head instruction; NOP when not valid
//   w_pc         out  head pc; 0 when not valid
//   w_count      out  number of occupied entries
module m_ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP      = 32'h13
) (
    input  logic                       w_clock,
    input  logic                       w_reset,
    output logic                       w_imem_req,
    output logic [31:0]                w_imem_addr,
    input  logic [31:0]                w_imem_data,
    input  logic                       w_redirect,
    input  logic [31:0]                w_tpc,
    input  logic                       w_ready,
    output logic                       w_valid,
    output logic [31:0]                w_ir,
    output logic [31:0]                w_pc,
    output logic [$clog2(DEPTH):0]     w_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_fpc;
    logic [31:0]   r_ipc;
    logic          r_inflight;
    logic [31:0]   r_mem_pc [DEPTH];
    logic [31:0]   r_mem_ir [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic [CW:0]   w_credit;
    logic          w_push;
    logic          w_pop;

    // Occupied plus reserved slots; a request is only issued when its
    // response is guaranteed room, so a push never meets a full FIFO.
    assign w_credit    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_imem_req  = !w_reset && !w_redirect && (w_credit < (CW+1)'(DEPTH));
    assign w_imem_addr = r_fpc;

    assign w_push  = r_inflight && !w_redirect;
    assign w_valid = (r_count != '0) && !w_redirect && !w_reset;
    assign w_pop   = w_valid && w_ready;

    // Head is read straight from storage, so w_imem_data never reaches an output.
    assign w_ir    = w_valid ? r_mem_ir[r_rd] : NOP;
    assign w_pc    = w_valid ? r_mem_pc[r_rd] : '0;
    assign w_count = r_count;

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            r_fpc      <= RESET_PC;
            r_inflight <= 1'b0;
            r_ipc      <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else if (w_redirect) begin
            r_fpc      <= w_tpc & ~32'h3;
            r_inflight <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            if (w_imem_req) begin
                r_fpc      <= r_fpc + 32'd4;
                r_inflight <= 1'b1;
                r_ipc      <= r_fpc;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once counted.
    always_ff @(posedge w_clock) begin
        if (w_push && !w_reset) begin
            r_mem_pc[r_wr] <= r_ipc;
            r_mem_ir[r_wr] <= w_imem_data;
        end
    end

    a_no_overflow: assert property (@(posedge w_clock) disable iff (w_reset)
        !(w_push && !w_pop && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Testbench for m_ifetch_queue: cycle-by-cycle vector table covering reset,
// fill/drain, redirect and reset-while-full, followed by a random-ready
// stream with periodic redirects checked against a pc sequence model.
module tb_m_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] tpc;
    logic        ready;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: returns 0x1000 + address one cycle after the request.
    always @(posedge clk) imem_data <= imem_req ? (32'h1000 + imem_addr) : 32'hDEAD_BEEF;

    m_ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .NOP      (32'h13)
    ) dut (
        .w_clock     (clk),
        .w_reset     (rst),
        .w_imem_req  (imem_req),
        .w_imem_addr (imem_addr),
        .w_imem_data (imem_data),
        .w_redirect  (redirect),
        .w_tpc       (tpc),
        .w_ready     (ready),
        .w_valid     (valid),
        .w_ir        (ir),
        .w_pc        (pc),
        .w_count     (count)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic rd, input logic [31:0] t, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt);
        vec_t x;
        x.rst = r; x.redir = rd; x.tpc = t; x.rdy = rdy;
        x.e_req = e_req; x.e_addr = e_addr; x.e_valid = e_valid;
        x.e_pc = e_pc; x.e_cnt = e_cnt;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_ir;
        logic [31:0] exp_next;
        int          n_acc;

        // rst redir tpc    rdy | req addr   valid pc     cnt
        // Reset, then stream with ready=1
        v(1, 0, 0,     1,  0, 32'h00, 0, 32'h00, 0);
        v(1, 0, 0,     1,  0, 32'h00, 0, 32'h00, 0);
        v(0, 0, 0,     1,  1, 32'h00, 0, 32'h00, 0);
        v(0, 0, 0,     1,  1, 32'h04, 0, 32'h00, 0);
        v(0, 0, 0,     1,  1, 32'h08, 1, 32'h00, 1);
        v(0, 0, 0,     1,  1, 32'h0C, 1, 32'h04, 1);
        v(0, 0, 0,     1,  1, 32'h10, 1, 32'h08, 1);
        v(0, 0, 0,     1,  1, 32'h14, 1, 32'h0C, 1);
        // Redirect with ready=1 while head would be valid and a fetch is in flight
        v(0, 1, 32'h42, 1, 0, 32'h18, 0, 32'h00, 1);
        v(0, 0, 0,     1,  1, 32'h40, 0, 32'h00, 0);
        v(0, 0, 0,     1,  1, 32'h44, 0, 32'h00, 0);
        v(0, 0, 0,     1,  1, 32'h48, 1, 32'h40, 1);
        v(0, 0, 0,     1,  1, 32'h4C, 1, 32'h44, 1);
        // One reset cycle mid-stream, then fill with ready=0
        v(1, 0, 0,     0,  0, 32'h50, 0, 32'h00, 1);
        v(0, 0, 0,     0,  1, 32'h00, 0, 32'h00, 0);
        v(0, 0, 0,     0,  1, 32'h04, 0, 32'h00, 0);
        v(0, 0, 0,     0,  1, 32'h08, 1, 32'h00, 1);
        v(0, 0, 0,     0,  1, 32'h0C, 1, 32'h00, 2);
        v(0, 0, 0,     0,  0, 32'h10, 1, 32'h00, 3);
        v(0, 0, 0,     0,  0, 32'h10, 1, 32'h00, 4);
        // Reset while full
        v(1, 0, 0,     0,  0, 32'h10, 0, 32'h00, 4);
        v(0, 0, 0,     0,  1, 32'h00, 0, 32'h00, 0);
        v(0, 0, 0,     0,  1, 32'h04, 0, 32'h00, 0);
        v(0, 0, 0,     0,  1, 32'h08, 1, 32'h00, 1);
        v(0, 0, 0,     0,  1, 32'h0C, 1, 32'h00, 2);
        v(0, 0, 0,     0,  0, 32'h10, 1, 32'h00, 3);
        v(0, 0, 0,     0,  0, 32'h10, 1, 32'h00, 4);
        // Drain in order while refilling
        v(0, 0, 0,     1,  0, 32'h10, 1, 32'h00, 4);
        v(0, 0, 0,     1,  1, 32'h10, 1, 32'h04, 3);
        v(0, 0, 0,     1,  1, 32'h14, 1, 32'h08, 2);
        v(0, 0, 0,     1,  1, 32'h18, 1, 32'h0C, 2);
        v(0, 0, 0,     1,  1, 32'h1C, 1, 32'h10, 2);
        v(0, 0, 0,     1,  1, 32'h20, 1, 32'h14, 2);

        // Inputs are applied just after a posedge and checked at the negedge.
        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            redirect = vecs[i].redir;
            tpc      = vecs[i].tpc;
            ready    = vecs[i].rdy;
            @(negedge clk);
            e_ir = vecs[i].e_valid ? (32'h1000 + vecs[i].e_pc) : 32'h13;
            chk("req",   i, {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk("addr",  i, imem_addr,         vecs[i].e_addr);
            chk("valid", i, {31'b0, valid},    {31'b0, vecs[i].e_valid});
            chk("pc",    i, pc,                vecs[i].e_pc);
            chk("ir",    i, ir,                e_ir);
            chk("count", i, {29'b0, count},    {29'b0, vecs[i].e_cnt});
            @(posedge clk);
            #1;
        end

        // Random ready stream with periodic redirects to 0x80.
        rst = 1'b1; redirect = 1'b0; tpc = 32'h0; ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_next = 32'h0;
        n_acc = 0;
        for (int k = 0; k < 200; k++) begin
            ready    = 1'($urandom_range(0, 1));
            redirect = (k % 37) == 36;
            tpc      = 32'h80;
            @(negedge clk);
            total++;
            if (count > 3'd4) begin
                bad++;
                $display("FAIL rnd_count cycle=%0d actual=%0d limit=4", k, count);
            end
            if (redirect) begin
                chk("rnd_redir_valid", k, {31'b0, valid}, 32'h0);
                exp_next = 32'h80;
            end else if (valid && ready) begin
                chk("rnd_pc", k, pc, exp_next);
                chk("rnd_ir", k, ir, 32'h1000 + exp_next);
                exp_next = exp_next + 32'd4;
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        redirect = 1'b0;
        total++;
        if (n_acc < 40) begin
            bad++;
            $display("FAIL rnd_throughput actual=%0d required>=40", n_acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
